// File: rtl/perceptron_trainer.sv
// Perceptron trainer: decides whether a resolved branch needs training, then
// reads one weight row, nudges each weight by +/-1 with saturation and writes it back.
module perceptron_trainer #(
    parameter int unsigned ROWS  = 228,
    parameter int unsigned THETA = 27,
    parameter int unsigned WBITS = 9,
    parameter int unsigned NW    = 8
) (
    input  logic                  fire,
    input  logic                  rst_n,
    input  logic                  i_valid_1,
    output logic                  o_ready_1,
    input  logic [7:0]            i_row_8,
    input  logic [NW-2:0]         i_hist_7,
    input  logic [11:0]           i_sum_12,
    input  logic                  i_actual_1,
    output logic                  o_rdEn_1,
    output logic [7:0]            o_rdRow_8,
    input  logic [WBITS*NW-1:0]   i_rdData_72,
    output logic                  o_wrEn_1,
    output logic [7:0]            o_wrRow_8,
    output logic [WBITS*NW-1:0]   o_wrData_72,
    output logic                  o_mispred_1,
    output logic                  o_badRow_1,
    output logic [15:0]           o_trainCnt_16,
    output logic [15:0]           o_mispredCnt_16
);

    localparam int unsigned KW = $clog2(NW);
    localparam logic [WBITS-1:0] WMax = {1'b0, {(WBITS-1){1'b1}}};
    localparam logic [WBITS-1:0] WMin = {1'b1, {(WBITS-1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StRead, StLoad, StUpd, StWrite} state_e;

    state_e                 state_q, state_d;
    logic [7:0]             row_q, row_d;
    logic [NW-2:0]          hist_q, hist_d;
    logic                   actual_q, actual_d;
    logic [KW-1:0]          k_q, k_d;
    logic [WBITS*NW-1:0]    buf_q, buf_d;
    logic                   mispred_q, mispred_d;
    logic                   bad_q, bad_d;
    logic [15:0]            train_cnt_q, train_cnt_d;
    logic [15:0]            mispred_cnt_q, mispred_cnt_d;

    // Prediction check on the incoming request.
    logic signed [12:0] sum_ext;
    logic [12:0]        sum_abs;
    logic               mis, train, row_bad;

    // Per-weight update datapath for the weight selected by k_q.
    int unsigned        base;
    logic [WBITS-1:0]   w_cur, w_new;
    logic [NW-1:0]      x_pos;
    logic               step_up;

    // Request decode and weight update arithmetic.
    always_comb begin
        sum_ext = {i_sum_12[11], i_sum_12};
        // 13-bit magnitude so that -2048 maps to 2048 rather than wrapping.
        sum_abs = i_sum_12[11] ? 13'(-sum_ext) : 13'(sum_ext);
        mis     = (~i_sum_12[11]) ^ i_actual_1;
        train   = mis | (32'(sum_abs) <= THETA);
        row_bad = 32'(i_row_8) >= ROWS;

        base    = 32'(k_q) * WBITS;
        w_cur   = buf_q[base +: WBITS];
        // Bias input is always +1; others follow the history bit.
        x_pos   = {hist_q, 1'b1};
        step_up = (x_pos[k_q] == actual_q);
        if (step_up) begin
            w_new = (w_cur == WMax) ? WMax : w_cur + 1'b1;
        end else begin
            w_new = (w_cur == WMin) ? WMin : w_cur - 1'b1;
        end
    end

    // Next-state logic for the FSM, buffer and counters.
    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        hist_d        = hist_q;
        actual_d      = actual_q;
        k_d           = k_q;
        buf_d         = buf_q;
        mispred_d     = 1'b0;
        bad_d         = 1'b0;
        train_cnt_d   = train_cnt_q;
        mispred_cnt_d = mispred_cnt_q;

        case (state_q)
            StIdle: begin
                if (i_valid_1) begin
                    row_d     = i_row_8;
                    hist_d    = i_hist_7;
                    actual_d  = i_actual_1;
                    mispred_d = mis;
                    bad_d     = row_bad;
                    if (mis && mispred_cnt_q != 16'hFFFF) begin
                        mispred_cnt_d = mispred_cnt_q + 16'd1;
                    end
                    if (!row_bad && train) begin
                        state_d = StRead;
                    end
                end
            end
            StRead: begin
                state_d = StLoad;
            end
            StLoad: begin
                buf_d   = i_rdData_72;
                k_d     = '0;
                state_d = StUpd;
            end
            StUpd: begin
                buf_d[base +: WBITS] = w_new;
                k_d                  = k_q + 1'b1;
                if (k_q == KW'(NW - 1)) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (train_cnt_q != 16'hFFFF) begin
                    train_cnt_d = train_cnt_q + 16'd1;
                end
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge fire) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            row_q         <= '0;
            hist_q        <= '0;
            actual_q      <= 1'b0;
            k_q           <= '0;
            buf_q         <= '0;
            mispred_q     <= 1'b0;
            bad_q         <= 1'b0;
            train_cnt_q   <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            hist_q        <= hist_d;
            actual_q      <= actual_d;
            k_q           <= k_d;
            buf_q         <= buf_d;
            mispred_q     <= mispred_d;
            bad_q         <= bad_d;
            train_cnt_q   <= train_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign o_ready_1       = (state_q == StIdle);
    assign o_rdEn_1        = (state_q == StRead);
    assign o_wrEn_1        = (state_q == StWrite);
    assign o_rdRow_8       = row_q;
    assign o_wrRow_8       = row_q;
    assign o_wrData_72     = buf_q;
    assign o_mispred_1     = mispred_q;
    assign o_badRow_1      = bad_q;
    assign o_trainCnt_16   = train_cnt_q;
    assign o_mispredCnt_16 = mispred_cnt_q;

endmodule

// File: tb/tb_perceptron_trainer.sv
// Self-checking bench for perceptron_trainer: table vectors, random requests
// against an integer reference model, backpressure and mid-operation reset.
module tb_perceptron_trainer;

    logic        fire;
    logic        rst_n;
    logic        i_valid_1;
    logic        o_ready_1;
    logic [7:0]  i_row_8;
    logic [6:0]  i_hist_7;
    logic [11:0] i_sum_12;
    logic        i_actual_1;
    logic        o_rdEn_1;
    logic [7:0]  o_rdRow_8;
    logic [71:0] i_rdData_72;
    logic        o_wrEn_1;
    logic [7:0]  o_wrRow_8;
    logic [71:0] o_wrData_72;
    logic        o_mispred_1;
    logic        o_badRow_1;
    logic [15:0] o_trainCnt_16;
    logic [15:0] o_mispredCnt_16;

    perceptron_trainer dut (
        .fire            (fire),
        .rst_n           (rst_n),
        .i_valid_1       (i_valid_1),
        .o_ready_1       (o_ready_1),
        .i_row_8         (i_row_8),
        .i_hist_7        (i_hist_7),
        .i_sum_12        (i_sum_12),
        .i_actual_1      (i_actual_1),
        .o_rdEn_1        (o_rdEn_1),
        .o_rdRow_8       (o_rdRow_8),
        .i_rdData_72     (i_rdData_72),
        .o_wrEn_1        (o_wrEn_1),
        .o_wrRow_8       (o_wrRow_8),
        .o_wrData_72     (o_wrData_72),
        .o_mispred_1     (o_mispred_1),
        .o_badRow_1      (o_badRow_1),
        .o_trainCnt_16   (o_trainCnt_16),
        .o_mispredCnt_16 (o_mispredCnt_16)
    );

    initial fire = 1'b0;
    always #5 fire = ~fire;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exp_mis_cnt   = 0;
    int exp_train_cnt = 0;
    logic [71:0] mem [0:227];

    typedef struct {
        logic [7:0]  row;
        logic [6:0]  hist;
        logic [11:0] sum;
        logic        act;
        logic [71:0] init;
        logic        mis;
        logic        bad;
        logic        train;
        logic [71:0] exp_data;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Advance one clock; sample just after the edge and act as the weight table.
    task automatic tick();
        @(posedge fire);
        #1;
        cyc++;
        if (o_rdEn_1 && o_rdRow_8 < 8'd228) i_rdData_72 = mem[o_rdRow_8];
        if (o_wrEn_1 && o_wrRow_8 < 8'd228) mem[o_wrRow_8] = o_wrData_72;
    endtask

    // Reference: each weight moves by t*x and is clamped to [-256, 255].
    function automatic logic [71:0] ref_train(input logic [71:0] d, input logic [6:0] h,
                                              input logic a);
        logic [71:0] r;
        r = d;
        for (int k = 0; k < 8; k++) begin
            logic signed [8:0] wv;
            int w, x, t;
            wv = d[k*9 +: 9];
            w  = int'(wv);
            if (k == 0) x = 1;
            else x = h[k-1] ? 1 : -1;
            t = a ? 1 : -1;
            w = w + t * x;
            if (w > 255) w = 255;
            if (w < -256) w = -256;
            r[k*9 +: 9] = w[8:0];
        end
        return r;
    endfunction

    task automatic ref_flags(input logic [7:0] row, input logic [11:0] sum, input logic act,
                             output logic em, output logic eb, output logic et);
        logic signed [11:0] ss;
        int sv, mag;
        ss  = sum;
        sv  = int'(ss);
        mag = (sv < 0) ? -sv : sv;
        em  = ((sv >= 0) ? 1'b1 : 1'b0) != act;
        et  = em || (mag <= 27);
        eb  = (row >= 8'd228);
    endtask

    // Issue one request from an idle DUT and follow it to completion.
    task automatic run_req(input logic [7:0] row, input logic [6:0] hist, input logic [11:0] sum,
                           input logic act, input logic em, input logic eb, input logic et,
                           input logic [71:0] ed, input string nm);
        int  t1;
        bit  seen;
        i_valid_1  = 1'b1;
        i_row_8    = row;
        i_hist_7   = hist;
        i_sum_12   = sum;
        i_actual_1 = act;
        tick();
        i_valid_1 = 1'b0;
        t1 = cyc;
        if (em) exp_mis_cnt++;
        check($sformatf("%s mispred", nm), 72'(o_mispred_1), 72'(em));
        check($sformatf("%s badrow", nm), 72'(o_badRow_1), 72'(eb));
        check($sformatf("%s mispredcnt", nm), 72'(o_mispredCnt_16), 72'(exp_mis_cnt));
        if (!eb && et) begin
            check($sformatf("%s rden", nm), 72'(o_rdEn_1), 72'(1));
            check($sformatf("%s rdrow", nm), 72'(o_rdRow_8), 72'(row));
            check($sformatf("%s busy", nm), 72'(o_ready_1), 72'(0));
            tick();
            check($sformatf("%s mispred_end", nm), 72'(o_mispred_1), 72'(0));
            seen = 0;
            for (int i = 0; i < 20 && !seen; i++) begin
                if (o_wrEn_1) seen = 1;
                else tick();
            end
            check($sformatf("%s wr_seen", nm), 72'(seen), 72'(1));
            if (seen) begin
                check($sformatf("%s wr_latency", nm), 72'(cyc - t1), 72'(10));
                check($sformatf("%s wrrow", nm), 72'(o_wrRow_8), 72'(row));
                check($sformatf("%s wrdata", nm), o_wrData_72, ed);
            end
            tick();
            exp_train_cnt++;
            check($sformatf("%s ready_after", nm), 72'(o_ready_1), 72'(1));
            check($sformatf("%s traincnt", nm), 72'(o_trainCnt_16), 72'(exp_train_cnt));
        end else begin
            check($sformatf("%s no_rd", nm), 72'(o_rdEn_1), 72'(0));
            check($sformatf("%s ready", nm), 72'(o_ready_1), 72'(1));
        end
    endtask

    function automatic logic [71:0] rand_row();
        logic [71:0] r;
        for (int k = 0; k < 8; k++) begin
            logic [31:0] u;
            u = $urandom;
            case ($urandom_range(0, 3))
                0:       r[k*9 +: 9] = 9'h0FF;
                1:       r[k*9 +: 9] = 9'h100;
                default: r[k*9 +: 9] = u[8:0];
            endcase
        end
        return r;
    endfunction

    initial begin
        logic em, eb, et;
        logic [71:0] ed, eda, edb, da;
        int   ta, wa, s;
        bit   got_a, seen_ready, seen;
        logic [7:0] row;
        logic [6:0] hist;
        logic [11:0] sum;
        logic act;

        tbl[0]  = '{8'd3,   7'b1010101, 12'hFF6, 1'b1, 72'h0, 1'b1, 1'b0, 1'b1,
                    {9'h001, 9'h1FF, 9'h001, 9'h1FF, 9'h001, 9'h1FF, 9'h001, 9'h001}};
        tbl[1]  = '{8'd4,   7'h00, 12'd100, 1'b1, 72'h0, 1'b0, 1'b0, 1'b0, 72'h0};
        tbl[2]  = '{8'd6,   7'h7F, 12'd5,   1'b1, {8{9'h0FF}}, 1'b0, 1'b0, 1'b1, {8{9'h0FF}}};
        tbl[3]  = '{8'd7,   7'h7F, 12'hFFB, 1'b0, {8{9'h100}}, 1'b0, 1'b0, 1'b1, {8{9'h100}}};
        tbl[4]  = '{8'd228, 7'h00, 12'd3,   1'b0, 72'h0, 1'b1, 1'b1, 1'b1, 72'h0};
        tbl[5]  = '{8'd255, 7'h00, 12'd3,   1'b0, 72'h0, 1'b1, 1'b1, 1'b1, 72'h0};
        tbl[6]  = '{8'd20,  7'h7F, 12'd27,  1'b1, 72'h0, 1'b0, 1'b0, 1'b1, {8{9'h001}}};
        tbl[7]  = '{8'd21,  7'h7F, 12'd28,  1'b1, 72'h0, 1'b0, 1'b0, 1'b0, 72'h0};
        tbl[8]  = '{8'd22,  7'h7F, 12'hFE5, 1'b0, 72'h0, 1'b0, 1'b0, 1'b1, {8{9'h1FF}}};
        tbl[9]  = '{8'd23,  7'h7F, 12'hFE4, 1'b0, 72'h0, 1'b0, 1'b0, 1'b0, 72'h0};
        tbl[10] = '{8'd24,  7'h7F, 12'h800, 1'b0, 72'h0, 1'b0, 1'b0, 1'b0, 72'h0};
        tbl[11] = '{8'd227, 7'h7F, 12'd0,   1'b0, 72'h0, 1'b1, 1'b0, 1'b1, {8{9'h1FF}}};

        for (int r = 0; r < 228; r++) mem[r] = '0;
        rst_n       = 1'b0;
        i_valid_1   = 1'b0;
        i_row_8     = '0;
        i_hist_7    = '0;
        i_sum_12    = '0;
        i_actual_1  = 1'b0;
        i_rdData_72 = '0;
        tick();
        tick();
        check("reset ready", 72'(o_ready_1), 72'(1));
        check("reset rden", 72'(o_rdEn_1), 72'(0));
        check("reset wren", 72'(o_wrEn_1), 72'(0));
        check("reset mispred", 72'(o_mispred_1), 72'(0));
        check("reset badrow", 72'(o_badRow_1), 72'(0));
        check("reset traincnt", 72'(o_trainCnt_16), 72'(0));
        check("reset mispredcnt", 72'(o_mispredCnt_16), 72'(0));
        check("reset wrdata", o_wrData_72, 72'(0));
        check("reset rdrow", 72'(o_rdRow_8), 72'(0));
        rst_n = 1'b1;
        tick();

        // Table vectors; a skip is immediately followed by the next request.
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].row < 8'd228) mem[tbl[i].row] = tbl[i].init;
            run_req(tbl[i].row, tbl[i].hist, tbl[i].sum, tbl[i].act, tbl[i].mis,
                    tbl[i].bad, tbl[i].train, tbl[i].exp_data, $sformatf("vec%0d", i));
        end

        // Backpressure: request B is presented while A is being trained.
        mem[10] = rand_row();
        mem[11] = rand_row();
        eda = ref_train(mem[10], 7'h35, 1'b1);
        edb = ref_train(mem[11], 7'h4A, 1'b1);
        i_valid_1  = 1'b1;
        i_row_8    = 8'd10;
        i_hist_7   = 7'h35;
        i_sum_12   = 12'hFF6;
        i_actual_1 = 1'b1;
        tick();
        ta = cyc;
        exp_mis_cnt++;
        i_row_8    = 8'd11;
        i_hist_7   = 7'h4A;
        i_sum_12   = 12'd20;
        got_a = 0;
        seen_ready = 0;
        wa = -1;
        da = '0;
        for (int i = 0; i < 40 && !seen_ready; i++) begin
            tick();
            if (o_wrEn_1 && !got_a) begin
                got_a = 1;
                wa = cyc - ta;
                da = o_wrData_72;
            end
            if (o_ready_1) seen_ready = 1;
        end
        check("bp ready_seen", 72'(seen_ready), 72'(1));
        check("bp ready_cycle", 72'(cyc - ta), 72'(11));
        check("bp writeA_cycle", 72'(wa), 72'(10));
        check("bp writeA_data", da, eda);
        tick();
        i_valid_1 = 1'b0;
        check("bp acceptB_rden", 72'(o_rdEn_1), 72'(1));
        check("bp acceptB_rdrow", 72'(o_rdRow_8), 72'(11));
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (o_wrEn_1) seen = 1;
            else tick();
        end
        check("bp writeB_seen", 72'(seen), 72'(1));
        check("bp writeB_cycle", 72'(cyc - ta), 72'(22));
        check("bp writeB_data", o_wrData_72, edb);
        tick();
        exp_train_cnt += 2;
        check("bp traincnt", 72'(o_trainCnt_16), 72'(exp_train_cnt));
        check("bp mispredcnt", 72'(o_mispredCnt_16), 72'(exp_mis_cnt));

        // Random requests against the reference model.
        for (int n = 0; n < 40; n++) begin
            row  = 8'($urandom_range(0, 255));
            hist = 7'($urandom);
            act  = 1'($urandom);
            if ($urandom_range(0, 1) == 1) s = int'($urandom_range(0, 80)) - 40;
            else s = int'($urandom);
            sum = s[11:0];
            ed = '0;
            if (row < 8'd228) begin
                mem[row] = rand_row();
                ed = ref_train(mem[row], hist, act);
            end
            ref_flags(row, sum, act, em, eb, et);
            run_req(row, hist, sum, act, em, eb, et, ed, $sformatf("rnd%0d", n));
        end

        // Reset in the middle of training must abort the write.
        mem[5] = '0;
        i_valid_1  = 1'b1;
        i_row_8    = 8'd5;
        i_hist_7   = 7'h00;
        i_sum_12   = 12'hFF6;
        i_actual_1 = 1'b1;
        tick();
        i_valid_1 = 1'b0;
        check("midrst rden", 72'(o_rdEn_1), 72'(1));
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        tick();
        check("midrst ready", 72'(o_ready_1), 72'(1));
        check("midrst wren", 72'(o_wrEn_1), 72'(0));
        check("midrst traincnt", 72'(o_trainCnt_16), 72'(0));
        check("midrst mispredcnt", 72'(o_mispredCnt_16), 72'(0));
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (o_wrEn_1) seen = 1;
        end
        check("midrst no_write", 72'(seen), 72'(0));
        check("midrst idle", 72'(o_ready_1), 72'(1));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/perceptron_trainer.md
Name: perceptron_trainer

Overview:
- Training stage directly downstream of the branch tables block (global history register plus 228-row weight table).
- Takes one resolved conditional branch at a time and decides whether the perceptron needs training: on a misprediction, or when |sum| <= THETA.
- When training, reads the 72-bit weight row (8 signed 9-bit weights), adjusts one weight per cycle with saturation, and writes the row back.
- Also emits a one-cycle mispredict pulse for GHR repair and keeps saturating statistics counters.

Parameters:
- ROWS, 228, number of weight-table rows; a row index >= ROWS is illegal.
- THETA, 27, training threshold on |sum|.
- WBITS, 9, weight width, two's complement.
- NW, 8, weights per row; w0 is the bias (input +1), wk uses history bit k-1 for k = 1..7.

Ports:
- fire  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- i_valid_1  in  1  resolved-branch request valid.
- o_ready_1  out  1  trainer can accept a request.
- i_row_8  in  8  weight-table row index.
- i_hist_7  in  7  history direction bits used for the prediction (1 = taken → +1, 0 → -1).
- i_sum_12  in  12  signed perceptron output used for the prediction.
- i_actual_1  in  1  resolved direction (1 = taken).
- o_rdEn_1  out  1  weight-row read strobe.
- o_rdRow_8  out  8  row to read.
- i_rdData_72  in  72  row data, valid the cycle after o_rdEn_1; weight k occupies bits [9k+8:9k].
- o_wrEn_1  out  1  weight-row write strobe.
- o_wrRow_8  out  8  row to write.
- o_wrData_72  out  72  updated row.
- o_mispred_1  out  1  one-cycle pulse on acceptance when the prediction was wrong.
- o_badRow_1  out  1  one-cycle pulse when a request with row >= ROWS is dropped.
- o_trainCnt_16  out  16  count of rows written; saturates at 0xFFFF.
- o_mispredCnt_16  out  16  count of mispredictions; saturates at 0xFFFF.

Behaviour:
- Reset (rst_n = 0 at an edge):
  - state -> IDLE.
  - All strobes and pulses -> 0; o_ready_1 -> 1.
  - Both counters -> 0; o_rdRow/o_wrRow/o_wrData -> 0.
  - Takes priority over every other event. Reset during READ/LOAD/UPD/WRITE aborts the operation; no write is issued afterwards.
- Prediction rule:
  - predicted = (i_sum_12 >= 0).
  - mis = predicted != i_actual_1.
  - train = mis OR |i_sum_12| <= THETA.
  - |sum| is computed at 13 bits, so -2048 gives 2048.
- Accept (IDLE, i_valid_1 = 1, o_ready_1 = 1) at edge T:
  - Latch row, hist, actual and train.
  - o_mispred_1 = mis during cycle T+1; o_mispredCnt_16 increments on mis.
  - If row >= ROWS: o_badRow_1 = 1 during T+1, o_mispred_1 is still reported, state stays IDLE.
  - Else if !train: stay IDLE. o_ready_1 stays 1, so back-to-back accepts are allowed.
  - Else go to READ.
- Training state machine:
  - READ (cycle T+1): o_rdEn_1 = 1, o_rdRow_8 = latched row, o_ready_1 = 0.
  - LOAD (T+2): capture i_rdData_72 into the working buffer.
  - UPD (T+3 .. T+10): k = 0..7, one weight per cycle.
    - x0 = +1; xk = hist[k-1] ? +1 : -1.
    - t = actual ? +1 : -1.
    - wk <= sat(wk + t*xk), where sat clamps to [-256, +255].
    - The 3-bit counter ends at 7 and then moves to WRITE.
  - WRITE (T+11): o_wrEn_1 = 1 with row and buffer; o_trainCnt_16 increments.
  - Next state IDLE; o_ready_1 = 1 from T+12.
- Request-to-train latency: 11 cycles to the write strobe. Occupancy is 12 cycles; a skip occupies 1 cycle.
- o_ready_1 = 1 only in IDLE. i_valid_1 is ignored while busy, and the request is held by the producer.
- Counter saturation: at 0xFFFF, a counter holds its value.
- Weight-table write at T+11 is visible to a read issued at T+12 or later. No forwarding is required.
- o_rdEn_1 and o_wrEn_1 are never high in the same cycle.

Test Plan:
- Reset mid-op: accept row 5 with train = 1, drop rst_n at T+5 -> no o_wrEn_1 ever; o_ready_1 = 1, counters = 0 after the reset edge.
- Correct training:
  - Stimulus: row 3, sum = -10, actual = 1, hist = 7'b1010101, row data all weights = 0.
  - Response: o_mispred_1 pulse at T+1; o_rdEn_1 at T+1 with row 3; o_wrEn_1 at T+11.
  - Expected weights: w0 = +1; wk = +1 where hist[k-1] = 1, else -1.
  - Counters: o_trainCnt_16 = 1, o_mispredCnt_16 = 1.
- Skip path: sum = +100, actual = 1 -> no read/write, no mispred pulse; o_ready_1 stays 1; second request accepted at T+1.
- Saturation:
  - All weights = +255, actual = 1, hist = 7'h7F, sum = 5 -> all written weights = +255.
  - All weights = -256, actual = 0, sum = -5 -> all stay -256.
- Bad row: row = 228 and row = 255 with sum = +3, actual = 0 -> o_badRow_1 and o_mispred_1 pulse at T+1; no read; o_mispredCnt_16 = 2.
- Busy backpressure: hold i_valid_1 = 1 for 30 cycles with two different requests queued -> second request accepted exactly at T+12; second write at T+23.
